// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use stall unit for the rv32i pipeline.
// A shadow copy of EX and later stages tracks producers so each ID operand can pick its youngest forwarding source.
module fwd_hazard_unit #(
    parameter int NUM_SRC        = 2,
    parameter int NUM_FWD_STAGES = 2,
    parameter int REG_ADDR_W     = 5,
    parameter int LOAD_STAGE     = 2,
    localparam int SEL_W         = $clog2(NUM_FWD_STAGES + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          advance,
    input  logic                          flush,
    input  logic                          id_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0]         id_rd,
    input  logic                          id_we,
    input  logic                          id_is_load,
    output logic                          stall_id,
    output logic                          ex_valid,
    output logic [NUM_SRC*SEL_W-1:0]      ex_fwd_sel
);

    localparam int NP = NUM_FWD_STAGES;

    // Shadow entries: index 0 is EX, index NP is the write-back slot.
    logic                  valid_reg [0:NP];
    logic                  we_reg    [0:NP];
    logic                  load_reg  [0:NP];
    logic [REG_ADDR_W-1:0] rd_reg    [0:NP];

    logic [NUM_SRC-1:0] hazard;
    logic               capture;

    assign stall_id = id_valid && (|hazard) && !flush && !rst;
    assign capture  = id_valid && !stall_id && !flush;
    assign ex_valid = valid_reg[0];

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_op
            logic [REG_ADDR_W-1:0] rs;
            logic [SEL_W-1:0]      sel_next;
            logic [SEL_W-1:0]      sel_reg;
            logic                  hazard_op;

            assign rs = id_rs[gi*REG_ADDR_W +: REG_ADDR_W];

            // Scan oldest to youngest so the youngest producer overwrites older ones.
            always_comb begin
                sel_next  = '0;
                hazard_op = 1'b0;
                for (int p = NP - 1; p >= 0; p--) begin
                    if (valid_reg[p] && we_reg[p] && (rd_reg[p] == rs) && (rs != '0)) begin
                        sel_next  = SEL_W'(p + 1);
                        hazard_op = load_reg[p] && ((p + 1) < LOAD_STAGE);
                    end
                end
            end

            assign hazard[gi] = hazard_op;

            always_ff @(posedge clk) begin
                if (rst) begin
                    sel_reg <= '0;
                end else if (advance) begin
                    sel_reg <= capture ? sel_next : '0;
                end
            end

            assign ex_fwd_sel[gi*SEL_W +: SEL_W] = sel_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= NP; k++) begin
                valid_reg[k] <= 1'b0;
                we_reg[k]    <= 1'b0;
                load_reg[k]  <= 1'b0;
                rd_reg[k]    <= '0;
            end
        end else if (advance) begin
            for (int k = NP; k >= 1; k--) begin
                valid_reg[k] <= valid_reg[k-1];
                we_reg[k]    <= we_reg[k-1];
                load_reg[k]  <= load_reg[k-1];
                rd_reg[k]    <= rd_reg[k-1];
            end
            // A stalled or flushed ID slot enters EX as a bubble.
            valid_reg[0] <= capture;
            we_reg[0]    <= capture && id_we;
            load_reg[0]  <= capture && id_is_load;
            rd_reg[0]    <= capture ? id_rd : '0;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed pipeline scenarios plus a randomized run
// checked against a queue-based pipeline model.
module tb_fwd_hazard_unit;

    localparam int N  = 2;
    localparam int NS = 2;
    localparam int AW = 5;
    localparam int LS = 2;
    localparam int SW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              advance;
    logic              flush;
    logic              id_valid;
    logic [NS*AW-1:0]  id_rs;
    logic [AW-1:0]     id_rd;
    logic              id_we;
    logic              id_is_load;
    logic              stall_id;
    logic              ex_valid;
    logic [NS*SW-1:0]  ex_fwd_sel;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic          v;
        logic [AW-1:0] rd;
        logic          we;
        logic          ld;
    } ent_t;

    ent_t          pipe[$];
    logic [SW-1:0] m_sel [NS];

    fwd_hazard_unit dut (
        .clk        (clk),
        .rst        (rst),
        .advance    (advance),
        .flush      (flush),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rd      (id_rd),
        .id_we      (id_we),
        .id_is_load (id_is_load),
        .stall_id   (stall_id),
        .ex_valid   (ex_valid),
        .ex_fwd_sel (ex_fwd_sel)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int youngest(input logic [AW-1:0] r);
        if (r == 0) return -1;
        for (int p = 0; p < N; p++)
            if (pipe[p].v && pipe[p].we && pipe[p].rd == r) return p;
        return -1;
    endfunction

    function automatic logic m_stall();
        if (!id_valid || flush || rst) return 1'b0;
        for (int i = 0; i < NS; i++) begin
            int p;
            p = youngest(id_rs[i*AW +: AW]);
            if (p >= 0 && pipe[p].ld && (p + 1) < LS) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [NS*SW-1:0] m_sel_packed();
        logic [NS*SW-1:0] s;
        for (int i = 0; i < NS; i++) s[i*SW +: SW] = m_sel[i];
        return s;
    endfunction

    task automatic model_clear();
        ent_t e;
        e = '{v: 1'b0, rd: '0, we: 1'b0, ld: 1'b0};
        pipe.delete();
        for (int k = 0; k <= N; k++) pipe.push_back(e);
        for (int i = 0; i < NS; i++) m_sel[i] = '0;
    endtask

    // Advance the model with the current inputs, then clock the DUT.
    task automatic tick();
        logic st;
        logic cap;
        ent_t e;
        st = m_stall();
        if (rst) begin
            model_clear();
        end else if (advance) begin
            cap = id_valid && !st && !flush;
            for (int i = 0; i < NS; i++) begin
                int p;
                p = youngest(id_rs[i*AW +: AW]);
                m_sel[i] = (cap && p >= 0) ? SW'(p + 1) : '0;
            end
            e = cap ? '{v: 1'b1, rd: id_rd, we: id_we, ld: id_is_load}
                    : '{v: 1'b0, rd: '0, we: 1'b0, ld: 1'b0};
            pipe.push_front(e);
            void'(pipe.pop_back());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic adv, input logic fl, input logic v,
                          input logic [AW-1:0] rs0, input logic [AW-1:0] rs1,
                          input logic [AW-1:0] rd, input logic we, input logic ld);
        advance    = adv;
        flush      = fl;
        id_valid   = v;
        id_rs      = {rs1, rs0};
        id_rd      = rd;
        id_we      = we;
        id_is_load = ld;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        set_in(1, 0, 1, 3, 3, 3, 1, 1);
        #1;
        n_checks++;
        if (stall_id !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b want=0", stall_id); end
        tick();
        tick();
        n_checks++;
        if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ex_valid got=%b want=0", ex_valid); end
        n_checks++;
        if (ex_fwd_sel !== '0) begin n_fail++; $display("FAIL reset_sel got=%h want=0", ex_fwd_sel); end
        $display("reset: ex_valid=%b sel=%h", ex_valid, ex_fwd_sel);
        rst = 1'b0;
    endtask

    task automatic test_forward();
        // add x5 in EX, ID reads rs1=x5
        do_reset();
        set_in(1, 0, 1, 0, 0, 5, 1, 0); tick();
        set_in(1, 0, 1, 5, 0, 6, 1, 0);
        @(negedge clk);
        n_checks++;
        if (stall_id !== 1'b0) begin n_fail++; $display("FAIL fwd_ex_stall got=%b want=0", stall_id); end
        tick();
        n_checks++;
        if (ex_fwd_sel !== 4'b0001) begin n_fail++; $display("FAIL fwd_ex_sel got=%h want=1", ex_fwd_sel); end
        $display("fwd ex: sel=%h", ex_fwd_sel);

        // add x5 at pos1, ID reads rs2=x5
        do_reset();
        set_in(1, 0, 1, 0, 0, 5, 1, 0); tick();
        set_in(1, 0, 0, 0, 0, 0, 0, 0); tick();
        set_in(1, 0, 1, 1, 5, 6, 1, 0); tick();
        n_checks++;
        if (ex_fwd_sel !== 4'b1000) begin n_fail++; $display("FAIL fwd_mem_sel got=%h want=8", ex_fwd_sel); end
        $display("fwd mem: sel=%h", ex_fwd_sel);

        // x5 in EX and pos1: youngest wins
        do_reset();
        set_in(1, 0, 1, 0, 0, 5, 1, 0); tick();
        set_in(1, 0, 1, 0, 0, 5, 1, 0); tick();
        set_in(1, 0, 1, 5, 5, 6, 1, 0); tick();
        n_checks++;
        if (ex_fwd_sel !== 4'b0101) begin n_fail++; $display("FAIL fwd_youngest got=%h want=5", ex_fwd_sel); end
        $display("fwd youngest: sel=%h", ex_fwd_sel);

        // producer of x0 never forwards or stalls
        do_reset();
        set_in(1, 0, 1, 0, 0, 0, 1, 1); tick();
        set_in(1, 0, 1, 0, 0, 6, 1, 0);
        @(negedge clk);
        n_checks++;
        if (stall_id !== 1'b0) begin n_fail++; $display("FAIL x0_stall got=%b want=0", stall_id); end
        tick();
        n_checks++;
        if (ex_fwd_sel !== 4'b0000) begin n_fail++; $display("FAIL x0_sel got=%h want=0", ex_fwd_sel); end
        $display("x0: sel=%h", ex_fwd_sel);
    endtask

    task automatic test_load_use();
        do_reset();
        set_in(1, 0, 1, 0, 0, 7, 1, 1); tick();
        set_in(1, 0, 1, 7, 0, 8, 1, 0);
        @(negedge clk);
        n_checks++;
        if (stall_id !== 1'b1) begin n_fail++; $display("FAIL lu_stall got=%b want=1", stall_id); end
        tick();
        n_checks++;
        if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL lu_bubble got=%b want=0", ex_valid); end
        n_checks++;
        if (stall_id !== 1'b0) begin n_fail++; $display("FAIL lu_release got=%b want=0", stall_id); end
        tick();
        n_checks++;
        if (ex_fwd_sel !== 4'b0010 || ex_valid !== 1'b1) begin
            n_fail++; $display("FAIL lu_sel got=%h/%b want=2/1", ex_fwd_sel, ex_valid);
        end
        $display("load-use: sel=%h ex_valid=%b", ex_fwd_sel, ex_valid);
    endtask

    task automatic test_adv_hold();
        do_reset();
        set_in(1, 0, 1, 0, 0, 7, 1, 1); tick();
        set_in(0, 0, 1, 7, 0, 8, 1, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (stall_id !== 1'b1) begin n_fail++; $display("FAIL hold_stall c=%0d got=%b want=1", c, stall_id); end
            tick();
            n_checks++;
            if (ex_valid !== 1'b1 || ex_fwd_sel !== 4'b0000) begin
                n_fail++; $display("FAIL hold_state c=%0d got=%b/%h want=1/0", c, ex_valid, ex_fwd_sel);
            end
            $display("hold c=%0d: ex_valid=%b sel=%h", c, ex_valid, ex_fwd_sel);
        end
        advance = 1'b1;
        tick();
        n_checks++;
        if (ex_valid !== 1'b0 || stall_id !== 1'b0) begin
            n_fail++; $display("FAIL hold_bubble got=%b/%b want=0/0", ex_valid, stall_id);
        end
        tick();
        n_checks++;
        if (ex_fwd_sel !== 4'b0010) begin n_fail++; $display("FAIL hold_sel got=%h want=2", ex_fwd_sel); end
        $display("hold done: sel=%h", ex_fwd_sel);
    endtask

    task automatic test_flush_reset();
        do_reset();
        set_in(1, 0, 1, 0, 0, 7, 1, 1); tick();
        set_in(1, 1, 1, 7, 0, 8, 1, 0);
        @(negedge clk);
        n_checks++;
        if (stall_id !== 1'b0) begin n_fail++; $display("FAIL flush_stall got=%b want=0", stall_id); end
        tick();
        n_checks++;
        if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL flush_ex got=%b want=0", ex_valid); end
        $display("flush: ex_valid=%b", ex_valid);

        do_reset();
        set_in(1, 0, 1, 0, 0, 7, 1, 1); tick();
        set_in(1, 0, 1, 7, 0, 8, 1, 0);
        @(negedge clk);
        n_checks++;
        if (stall_id !== 1'b1) begin n_fail++; $display("FAIL rst_pre_stall got=%b want=1", stall_id); end
        rst = 1'b1;
        #1;
        n_checks++;
        if (stall_id !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stall got=%b want=0", stall_id); end
        tick();
        n_checks++;
        if (ex_valid !== 1'b0 || ex_fwd_sel !== '0) begin
            n_fail++; $display("FAIL rst_mid_state got=%b/%h want=0/0", ex_valid, ex_fwd_sel);
        end
        rst = 1'b0;
        $display("reset mid-stall: ex_valid=%b sel=%h", ex_valid, ex_fwd_sel);
    endtask

    task automatic test_random();
        logic exp_st;
        do_reset();
        for (int t = 0; t < 400; t++) begin
            rst = ($urandom_range(0, 99) < 2);
            set_in(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 8),
                   AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
                   ($urandom_range(0, 9) < 8), ($urandom_range(0, 2) == 0));
            @(negedge clk);
            exp_st = m_stall();
            n_checks++;
            if (stall_id !== exp_st) begin n_fail++; $display("FAIL rnd_stall t=%0d got=%b want=%b", t, stall_id, exp_st); end
            tick();
            n_checks++;
            if (ex_valid !== pipe[0].v) begin n_fail++; $display("FAIL rnd_ex_valid t=%0d got=%b want=%b", t, ex_valid, pipe[0].v); end
            n_checks++;
            if (ex_fwd_sel !== m_sel_packed()) begin
                n_fail++; $display("FAIL rnd_sel t=%0d got=%h want=%h", t, ex_fwd_sel, m_sel_packed());
            end
            $display("rnd t=%0d rs=%h stall=%b ex_valid=%b sel=%h", t, id_rs, exp_st, ex_valid, ex_fwd_sel);
        end
        rst = 1'b0;
    endtask

    initial begin
        model_clear();
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        test_reset();
        test_forward();
        test_load_use();
        test_adv_hold();
        test_flush_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
